// File: rtl/vex_pair_streamer_if.sv
// Bundles for vex_pair_streamer: the compute_vex write stream
// and the valid/ready pair stream toward the backward-induction PE.
interface vex_wr_if #(
  parameter int ADDR_W = 13
);
  logic              wren;
  logic [ADDR_W-1:0] wraddr;
  logic [63:0]       v_ex;

  modport master (output wren, wraddr, v_ex);
  modport slave  (input  wren, wraddr, v_ex);
endinterface

interface vex_pair_if #(
  parameter int ADDR_W = 13
);
  logic              pair_valid;
  logic              pair_ready;
  logic [63:0]       pair_lo;
  logic [63:0]       pair_hi;
  logic [ADDR_W-1:0] pair_idx;
  logic              pair_last;

  modport master (
    output pair_valid, pair_lo, pair_hi,
    output pair_idx, pair_last,
    input  pair_ready
  );
  modport slave (
    input  pair_valid, pair_lo, pair_hi,
    input  pair_idx, pair_last,
    output pair_ready
  );
endinterface

// File: rtl/vex_pair_streamer.sv
// Column buffer: captures exercise values, replays adjacent pairs.
// Optional VEX_CLAMP_EN stores negative inputs as +0.0.
module vex_pair_streamer #(
  parameter int ADDR_W  = 13,
  parameter int N_NODES = 8001
) (
  input  logic       clk,
  input  logic       rst,
  vex_wr_if.slave    wr,
  input  logic       rd_start,
  output logic       col_full,
  vex_pair_if.master pr,
  output logic       busy,
  output logic       err
);
  localparam int CW    = ADDR_W + 1;
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [CW-1:0] NN = CW'(N_NODES);
  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(N_NODES - 2);

  typedef enum logic [2:0] {
    IDLE, FILL, FULL, PRIME, STREAM
  } state_e;

  typedef struct packed {
    logic [63:0]       lo;
    logic [63:0]       hi;
    logic [ADDR_W-1:0] idx;
  } pair_t;

  state_e            state_q, state_d;
  logic [CW-1:0]     wr_cnt_q, wr_cnt_d;
  logic [CW-1:0]     rd_ptr_q, rd_ptr_d;
  logic              err_q, err_d;
  logic              rd_vld_q, rd_vld_d;
  logic [ADDR_W-1:0] rd_idx_q, rd_idx_d;
  logic [63:0]       prev_q, prev_d;
  logic [63:0]       rdata_q;
  pair_t             ent_q [2];
  pair_t             ent_d [2];
  logic              rp_q, rp_d;
  logic              wp_q, wp_d;
  logic [1:0]        cnt_q, cnt_d;

  logic [63:0] mem [DEPTH];
  logic        wr_ok, rd_en, streaming;
  logic        push, pop, last_pop;
  logic [63:0] wdata;

`ifdef VEX_CLAMP_EN
  assign wdata = wr.v_ex[63] ? 64'h0 : wr.v_ex;
`else
  assign wdata = wr.v_ex;
`endif

  always_comb begin
    state_d  = state_q;
    wr_cnt_d = wr_cnt_q;
    rd_ptr_d = rd_ptr_q;
    err_d    = err_q;
    rd_idx_d = rd_idx_q;
    prev_d   = prev_q;
    ent_d    = ent_q;
    rp_d     = rp_q;
    wp_d     = wp_q;

    wr_ok = wr.wren
         && (state_q == IDLE || state_q == FILL)
         && ({1'b0, wr.wraddr} < NN);
    streaming = state_q == PRIME
             || state_q == STREAM;
    pop  = (cnt_q != 2'd0) && pr.pair_ready;
    push = rd_vld_q && (rd_idx_q != '0);
    last_pop = pop && (ent_q[rp_q].idx == LAST);
    // Issue a read only if its pair is sure to fit next cycle
    rd_en = streaming && (rd_ptr_q < NN)
         && (int'(cnt_q) + int'(push)
             - int'(pop) < 2);
    rd_vld_d = rd_en;

    if (wr.wren && !wr_ok) err_d = 1'b1;
    if (wr_ok) wr_cnt_d = wr_cnt_q + 1'b1;
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      rd_idx_d = rd_ptr_q[ADDR_W-1:0];
    end
    if (rd_vld_q) prev_d = rdata_q;

    if (push) begin
      ent_d[wp_q] = '{lo:  prev_q,
                      hi:  rdata_q,
                      idx: rd_idx_q - 1'b1};
      wp_d = ~wp_q;
    end
    if (pop) rp_d = ~rp_q;
    cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};

    unique case (state_q)
      IDLE, FILL: begin
        if (wr_ok)
          state_d = (wr_cnt_q + 1'b1 == NN)
                  ? FULL : FILL;
      end
      FULL: begin
        if (rd_start) begin
          state_d  = PRIME;
          rd_ptr_d = '0;
        end
      end
      PRIME: begin
        if (rd_en && rd_ptr_q == CW'(1))
          state_d = STREAM;
      end
      STREAM: begin
        if (last_pop) begin
          state_d  = IDLE;
          wr_cnt_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      wr_cnt_q <= '0;
      rd_ptr_q <= '0;
      err_q    <= 1'b0;
      rd_vld_q <= 1'b0;
      rd_idx_q <= '0;
      prev_q   <= '0;
      ent_q[0] <= '0;
      ent_q[1] <= '0;
      rp_q     <= 1'b0;
      wp_q     <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      wr_cnt_q <= wr_cnt_d;
      rd_ptr_q <= rd_ptr_d;
      err_q    <= err_d;
      rd_vld_q <= rd_vld_d;
      rd_idx_q <= rd_idx_d;
      prev_q   <= prev_d;
      ent_q    <= ent_d;
      rp_q     <= rp_d;
      wp_q     <= wp_d;
      cnt_q    <= cnt_d;
    end
  end

  // Column RAM survives reset by design
  always_ff @(posedge clk) begin
    if (wr_ok && !rst) mem[wr.wraddr] <= wdata;
    if (rd_en) rdata_q <= mem[rd_ptr_q[ADDR_W-1:0]];
  end

  assign pr.pair_valid = cnt_q != 2'd0;
  assign pr.pair_lo    = ent_q[rp_q].lo;
  assign pr.pair_hi    = ent_q[rp_q].hi;
  assign pr.pair_idx   = ent_q[rp_q].idx;
  assign pr.pair_last  = pr.pair_valid
                      && (ent_q[rp_q].idx == LAST);
  assign col_full = state_q == FULL;
  assign busy     = streaming;
  assign err      = err_q;
endmodule

// File: tb/tb_vex_pair_streamer.sv
// Bench for vex_pair_streamer: column model plus directed fills
// and replays, with a per-cycle pair comparator.
module tb_vex_pair_streamer;
  localparam int AW = 13;
  localparam int N  = 8001;
`ifdef VEX_CLAMP_EN
  localparam logic [63:0] NEG_EXP = 64'h0;
`else
  localparam logic [63:0] NEG_EXP = 64'hBFF0000000000000;
`endif

  logic clk = 1'b0;
  logic rst;
  logic rd_start;
  logic col_full, busy, err;

  vex_wr_if   #(.ADDR_W(AW)) wif ();
  vex_pair_if #(.ADDR_W(AW)) pif ();

  vex_pair_streamer #(
    .ADDR_W (AW),
    .N_NODES(N)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .wr      (wif),
    .rd_start(rd_start),
    .col_full(col_full),
    .pr      (pif),
    .busy    (busy),
    .err     (err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  logic [63:0] mdl_mem [8192];
  bit  stream_on = 1'b0;
  int  stream_id = 0;
  int  exp_next  = 0;
  int  hs_cnt    = 0;
  int  last_cnt  = 0;
  int  last_idx  = -1;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h",
               nm, act, req);
    end
  endtask

  function automatic logic [63:0] clampf(
    input logic [63:0] v);
`ifdef VEX_CLAMP_EN
    return v[63] ? 64'h0 : v;
`else
    return v;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected pair k is (v[k], v[k+1]), strictly in order
  always @(negedge clk) begin
    if (!rst) begin
      if (stream_on && exp_next < N - 1) begin
        if (pif.pair_valid) begin
          chk("pair_idx", pif.pair_idx,
              64'(exp_next));
          chk("pair_lo", pif.pair_lo,
              mdl_mem[exp_next]);
          chk("pair_hi", pif.pair_hi,
              mdl_mem[exp_next + 1]);
          chk("pair_last", pif.pair_last,
              64'(exp_next == N - 2));
          if (stream_id == 2 && exp_next == 4)
            chk("idx4_hi_lit", pif.pair_hi,
                NEG_EXP);
          if (pif.pair_ready) begin
            if (pif.pair_last) begin
              last_cnt++;
              last_idx = exp_next;
            end
            exp_next++;
            hs_cnt++;
          end
        end
      end else begin
        chk("no_pair", pif.pair_valid, 0);
      end
    end
  end

  task automatic start_stream(input int id);
    stream_on = 1'b1;
    stream_id = id;
    exp_next  = 0;
    hs_cnt    = 0;
    last_cnt  = 0;
    last_idx  = -1;
  endtask

  task automatic fill(input int kind);
    for (int a = 0; a < N; a++) begin
      logic [63:0] v;
      v = (kind == 2)
        ? $realtobits(real'(a) + 0.5)
        : $realtobits(real'(a));
      if (kind == 1 && a == 5)
        v = 64'hBFF0000000000000;
      if (kind == 0 && a == 200) begin
        chk("err_pre_oob", err, 0);
        wif.wren   = 1'b1;
        wif.wraddr = 13'(N);
        wif.v_ex   = 64'hDEADBEEF;
        tick();
        chk("err_oob", err, 1);
      end
      if (a == N - 1)
        chk("col_full_pre", col_full, 0);
      wif.wren   = 1'b1;
      wif.wraddr = 13'(a);
      wif.v_ex   = v;
      mdl_mem[a] = clampf(v);
      rd_start = (kind == 0)
              && (a == 100 || a == N - 1);
      tick();
      rd_start = 1'b0;
      if (kind == 0 && a == 100)
        chk("rd_start_fill", busy, 0);
    end
    wif.wren = 1'b0;
    chk("col_full", col_full, 1);
    chk("busy_full", busy, 0);
  endtask

  task automatic first_latency(
    input logic [63:0] lo,
    input logic [63:0] hi);
    int n;
    n = 0;
    while (!pif.pair_valid && n < 8) begin
      tick();
      n++;
    end
    chk("first_lat", 64'(n), 64'd3);
    chk("first_idx", pif.pair_idx, 0);
    chk("first_lo", pif.pair_lo, lo);
    chk("first_hi", pif.pair_hi, hi);
  endtask

  task automatic do_rst();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    stream_on = 1'b0;
  endtask

  initial begin
    bit pat [4];
    int cyc;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    rst = 1'b1;
    rd_start = 1'b0;
    wif.wren = 1'b0;
    wif.wraddr = '0;
    wif.v_ex = '0;
    pif.pair_ready = 1'b0;
    tick();
    tick();
    chk("rst_valid", pif.pair_valid, 0);
    chk("rst_lo", pif.pair_lo, 0);
    chk("rst_hi", pif.pair_hi, 0);
    chk("rst_idx", pif.pair_idx, 0);
    chk("rst_last", pif.pair_last, 0);
    chk("rst_full", col_full, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;

    // Column A: plain replay, full throughput
    fill(0);
    pif.pair_ready = 1'b1;
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    start_stream(1);
    chk("a_busy", busy, 1);
    chk("a_full_drop", col_full, 0);
    first_latency(64'h0, 64'h3FF0000000000000);
    cyc = 0;
    while (busy && cyc < 20000) begin
      tick();
      cyc++;
    end
    chk("a_done", busy, 0);
    chk("a_pairs", 64'(hs_cnt), 64'd8000);
    chk("a_last_cnt", 64'(last_cnt), 64'd1);
    chk("a_last_idx", 64'(last_idx), 64'd7999);
    chk("a_full_after", col_full, 0);

    // Column B: negative word, stalls, write while busy
    do_rst();
    chk("b_err_clr", err, 0);
    fill(1);
    pif.pair_ready = 1'b1;
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    start_stream(2);
    cyc = 0;
    while (busy && cyc < 40000) begin
      pif.pair_ready = pat[cyc % 4];
      wif.wren   = (cyc == 100);
      wif.wraddr = 13'd7000;
      wif.v_ex   = 64'hFFFF0000FFFF0000;
      if (cyc == 100) chk("b_err_pre", err, 0);
      tick();
      cyc++;
      if (cyc == 101) chk("b_err_busy", err, 1);
    end
    wif.wren = 1'b0;
    pif.pair_ready = 1'b1;
    chk("b_done", busy, 0);
    chk("b_pairs", 64'(hs_cnt), 64'd8000);
    chk("b_last_idx", 64'(last_idx), 64'd7999);

    // Column C: rd_start with a write in FULL, rst mid-stream
    do_rst();
    fill(2);
    chk("c_err_pre", err, 0);
    rd_start   = 1'b1;
    wif.wren   = 1'b1;
    wif.wraddr = 13'd7;
    wif.v_ex   = 64'h7FF8000000000000;
    tick();
    rd_start = 1'b0;
    wif.wren = 1'b0;
    start_stream(3);
    chk("c_err_full", err, 1);
    chk("c_busy", busy, 1);
    chk("c_full_drop", col_full, 0);
    first_latency(64'h3FE0000000000000,
                  64'h3FF8000000000000);
    cyc = 0;
    while (busy && hs_cnt < 100 && cyc < 1000) begin
      tick();
      cyc++;
    end
    chk("c_hs100", 64'(hs_cnt), 64'd100);
    do_rst();
    chk("c_rst_valid", pif.pair_valid, 0);
    chk("c_rst_lo", pif.pair_lo, 0);
    chk("c_rst_hi", pif.pair_hi, 0);
    chk("c_rst_busy", busy, 0);
    chk("c_rst_full", col_full, 0);
    chk("c_rst_err", err, 0);
    tick();
    tick();
    chk("c_idle_valid", pif.pair_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule
